// File: rtl/io_pkg.sv
// Shared constants for the MMIO board-I/O responder: register offsets,
// BTN bit positions, default window base and the debouncer state type.
package io_pkg;

  localparam logic [1:0]  OFF_SW    = 2'd0;
  localparam logic [1:0]  OFF_LED   = 2'd1;
  localparam logic [1:0]  OFF_BTN   = 2'd2;
  localparam logic [1:0]  OFF_TIMER = 2'd3;

  localparam int BTN_LEVEL = 0;
  localparam int BTN_EVENT = 1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hC000_0000;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Active-low pushbutton conditioner: 2-flop synchroniser on the pressed sense,
// then a counter FSM that only accepts a level held for DEBOUNCE_CYCLES cycles.
module button_debouncer
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          p_meta_q, p_sync_q;
  logic          mismatch_s;

  assign mismatch_s = p_sync_q ^ level_q;
  assign level      = level_q;

  // Synchroniser, FSM state, counter and accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      p_meta_q <= 1'b0;
      p_sync_q <= 1'b0;
      state_q  <= DB_STABLE;
      cnt_q    <= CNT_ZERO;
      level_q  <= 1'b0;
    end else begin
      p_meta_q <= ~raw_n;
      p_sync_q <= p_meta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
    end
  end

  // The first mismatching cycle already counts as 1, so the level flips
  // after exactly DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    rise_pulse = 1'b0;
    case (state_q)
      DB_STABLE: begin
        if (mismatch_s) begin
          state_d = DB_COUNTING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      DB_COUNTING: begin
        if (!mismatch_s) begin
          state_d = DB_STABLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = DB_STABLE;
          cnt_d      = CNT_ZERO;
          level_d    = p_sync_q;
          rise_pulse = p_sync_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/mmio_io_responder.sv
// Single-cycle MMIO target for a 16-byte window: switches, LEDs, debounced
// button with sticky press flag and a writable free-running cycle timer.
module mmio_io_responder
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          NUM_IO          = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              sel,
  input  logic [NUM_IO-1:0] switches,
  input  logic              button,
  output logic [NUM_IO-1:0] leds
);

  logic [1:0]        off_s;
  logic              wr_led_s, wr_btn_s, wr_timer_s;
  logic              btn_level_s, btn_rise_s;
  logic              unused_s;

  logic [NUM_IO-1:0] sw_meta_q, sw_sync_q;
  logic [NUM_IO-1:0] leds_q, leds_d;
  logic [31:0]       timer_q, timer_d;
  logic              event_q, event_d;

  assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
  assign off_s      = addr[3:2];
  assign unused_s   = ^addr[1:0];
  assign wr_led_s   = we & sel & (off_s == OFF_LED);
  assign wr_btn_s   = we & sel & (off_s == OFF_BTN);
  assign wr_timer_s = we & sel & (off_s == OFF_TIMER);
  assign leds       = leds_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk        (clk),
    .reset      (reset),
    .raw_n      (button),
    .level      (btn_level_s),
    .rise_pulse (btn_rise_s)
  );

  // Next-state for the writable registers; a press arriving with a clear keeps the flag
  always_comb begin
    leds_d  = wr_led_s   ? wdata[NUM_IO-1:0] : leds_q;
    timer_d = wr_timer_s ? wdata : (timer_q + 32'd1);
    event_d = btn_rise_s | (event_q & ~(wr_btn_s & wdata[BTN_EVENT]));
  end

  // Switch synchroniser and register state
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      leds_q    <= '0;
      timer_q   <= 32'd0;
      event_q   <= 1'b0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      leds_q    <= leds_d;
      timer_q   <= timer_d;
      event_q   <= event_d;
    end
  end

  // Zero-latency read mux, side-effect free
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (off_s)
        OFF_SW:    rdata = 32'(sw_sync_q);
        OFF_LED:   rdata = 32'(leds_q);
        OFF_BTN: begin
          rdata[BTN_LEVEL] = btn_level_s;
          rdata[BTN_EVENT] = event_q;
        end
        OFF_TIMER: rdata = timer_q;
        default:   rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule
